// File: rtl/sel_rs_if.sv
// sel_rs_if: dispatch, CDB, flush and FU issue bus of the select-FU reservation station
interface sel_rs_if #(
    parameter int TAG_W = 4
);
    logic                  flush;
    logic                  disp_valid;
    logic                  disp_ready;
    logic [7:0]            disp_operand;
    logic [1:0][TAG_W-1:0] disp_src_tag;
    logic [1:0]            disp_src_rdy;
    logic [1:0][7:0]       disp_src_val;
    logic [7:0]            disp_wbs;
    logic [7:0]            disp_flags;
    logic [TAG_W-1:0]      disp_robid;
    logic                  cdb_valid;
    logic [TAG_W-1:0]      cdb_id;
    logic [7:0]            cdb_val;
    logic                  fu_busy;
    logic                  issue_transmit;
    logic [7:0]            issue_operand;
    logic [1:0][7:0]       issue_depvals;
    logic [7:0]            issue_wbs;
    logic [7:0]            issue_flags;
    logic [TAG_W-1:0]      issue_robid;
    modport master (
        output flush, disp_valid, disp_operand, disp_src_tag, disp_src_rdy, disp_src_val,
               disp_wbs, disp_flags, disp_robid, cdb_valid, cdb_id, cdb_val, fu_busy,
        input  disp_ready, issue_transmit, issue_operand, issue_depvals, issue_wbs,
               issue_flags, issue_robid
    );
    modport slave (
        input  flush, disp_valid, disp_operand, disp_src_tag, disp_src_rdy, disp_src_val,
               disp_wbs, disp_flags, disp_robid, cdb_valid, cdb_id, cdb_val, fu_busy,
        output disp_ready, issue_transmit, issue_operand, issue_depvals, issue_wbs,
               issue_flags, issue_robid
    );
endinterface

// File: rtl/sel_rs.sv
// sel_rs: select-FU reservation station; define SEL_RS_WAKEUP_ISSUE_EN to let a CDB wakeup issue in the same cycle
module sel_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input logic     clk,
    input logic     rst_n,
    sel_rs_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    typedef struct packed {
        logic [7:0]            op;
        logic [1:0][TAG_W-1:0] tag;
        logic [1:0]            rdy;
        logic [1:0][7:0]       val;
        logic [7:0]            wbs;
        logic [7:0]            flags;
        logic [TAG_W-1:0]      robid;
    } ent_t;
    typedef struct packed {
        logic [7:0]       op;
        logic [1:0][7:0]  val;
        logic [7:0]       wbs;
        logic [7:0]       flags;
        logic [TAG_W-1:0] robid;
    } iss_t;
    ent_t ent_q [DEPTH];
    ent_t ent_d [DEPTH];
    ent_t wk [DEPTH];
    ent_t new_e;
    iss_t iss_q, iss_d;
    logic [CW-1:0] count_q, count_d, base;
    logic [IW-1:0] sel;
    logic [DEPTH-1:0] vld, elig;
    logic tx_q, tx_d, found, can, go_q, go_n, accept;

    assign bus.disp_ready = count_q < CW'(DEPTH);
    assign accept = bus.disp_valid && bus.disp_ready;
    assign can = !bus.fu_busy && !tx_q && !bus.flush;
    assign go_q = can && found;
    // a fully-ready dispatch goes straight to the FU when nothing queued can issue
    assign go_n = can && !found && accept && (&new_e.rdy);
    assign base = count_q - CW'(go_q);

    always_comb begin
        new_e.op = bus.disp_operand;
        new_e.wbs = bus.disp_wbs;
        new_e.flags = bus.disp_flags;
        new_e.robid = bus.disp_robid;
        new_e.tag = bus.disp_src_tag;
        for (int s = 0; s < 2; s++) begin
            new_e.rdy[s] = bus.disp_src_rdy[s] || (bus.cdb_valid && bus.cdb_id == bus.disp_src_tag[s]);
            new_e.val[s] = bus.disp_src_rdy[s] ? bus.disp_src_val[s] : bus.cdb_val;
        end
        new_e.rdy[1] = new_e.rdy[1] || bus.disp_flags[1];
        new_e.val[1] = bus.disp_flags[1] ? 8'h00 : new_e.val[1];
    end

    always_comb begin
        sel = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            vld[i] = CW'(i) < count_q;
            wk[i] = ent_q[i];
            for (int s = 0; s < 2; s++) begin
                if (bus.cdb_valid && !ent_q[i].rdy[s] && ent_q[i].tag[s] == bus.cdb_id) begin
                    wk[i].rdy[s] = 1'b1;
                    wk[i].val[s] = bus.cdb_val;
                end
            end
`ifdef SEL_RS_WAKEUP_ISSUE_EN
            elig[i] = vld[i] && (&wk[i].rdy);
`else
            elig[i] = vld[i] && (&ent_q[i].rdy);
`endif
            found = found || elig[i];
            sel = elig[i] ? IW'(i) : sel;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (go_q && IW'(i) >= sel) ? wk[(i + 1) % DEPTH] : wk[i];
            ent_d[i] = (accept && !go_n && CW'(i) == base) ? new_e : ent_d[i];
        end
        count_d = bus.flush ? '0 : base + CW'(accept && !go_n);
        tx_d = go_q || go_n;
        iss_d = go_q ? {wk[sel].op, wk[sel].val, wk[sel].wbs, wk[sel].flags, wk[sel].robid} :
                go_n ? {new_e.op, new_e.val, new_e.wbs, new_e.flags, new_e.robid} : iss_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tx_q <= 1'b0;
            iss_q <= '0;
        end else begin
            count_q <= count_d;
            tx_q <= tx_d;
            iss_q <= iss_d;
        end
    end

    always_ff @(posedge clk) ent_q <= ent_d;

    assign bus.issue_transmit = tx_q;
    assign bus.issue_operand = iss_q.op;
    assign bus.issue_depvals = iss_q.val;
    assign bus.issue_wbs = iss_q.wbs;
    assign bus.issue_flags = iss_q.flags;
    assign bus.issue_robid = iss_q.robid;
endmodule
